// File: rtl/rast_pkg.sv
// Shared rasterizer constants: register map, base-address width, control/status bit positions.
package rast_pkg;

  localparam int BASE_W = 26;

  localparam logic [15:0] ADDR_MV    = 16'h0000;
  localparam logic [15:0] ADDR_MVP   = 16'h0010;
  localparam logic [15:0] ADDR_LIGHT = 16'h0020;
  localparam logic [15:0] ADDR_FB    = 16'h0023;
  localparam logic [15:0] ADDR_VB    = 16'h0024;
  localparam logic [15:0] ADDR_CTRL  = 16'h0025;
  localparam logic [15:0] ADDR_TEST  = 16'h0026;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_DONE_BIT     = 1;
  localparam int TEST_BIT          = 0;

endpackage

// File: rtl/config_reg.sv
// Avalon-MM register file for the rasterizer: writes land same edge, reads return one cycle later.
// No wait states, no backpressure; start_render pulses once per accepted start, busy/done track completion.
module config_reg
  import rast_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int BASE_W = rast_pkg::BASE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] MV       [16],
  output logic [DATA_W-1:0] MVP      [16],
  output logic [DATA_W-1:0] lighting [3],
  output logic [BASE_W-1:0] frame_buffer_base,
  output logic [BASE_W-1:0] vertex_buffer_base,
  output logic              start_render,
  output logic              test,
  input  logic              done_in
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [DATA_W-1:0] r_mv    [16];
  logic [DATA_W-1:0] r_mvp   [16];
  logic [DATA_W-1:0] r_light [3];
  logic [BASE_W-1:0] r_fb;
  logic [BASE_W-1:0] r_vb;
  logic              r_test;
  logic [0:0]        r_state;
  logic              r_done;
  logic              r_start;
  logic [DATA_W-1:0] r_rdata;

  logic              w_is_mv;
  logic              w_is_mvp;
  logic              w_busy;
  logic              w_ctrl_wr;
  logic              w_start_req;
  logic              w_clr_done;
  logic [DATA_W-1:0] w_rdata;

  assign w_is_mv     = (address[ADDR_W-1:4] == ADDR_MV[ADDR_W-1:4]);
  assign w_is_mvp    = (address[ADDR_W-1:4] == ADDR_MVP[ADDR_W-1:4]);
  assign w_busy      = (r_state == BUSY);
  assign w_ctrl_wr   = write && (address == ADDR_CTRL);
  assign w_start_req = w_ctrl_wr && writedata[CTRL_START_BIT];
  assign w_clr_done  = w_ctrl_wr && writedata[CTRL_CLR_DONE_BIT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        r_mv[i]  <= '0;
        r_mvp[i] <= '0;
      end
      for (int i = 0; i < 3; i++) r_light[i] <= '0;
      r_fb   <= '0;
      r_vb   <= '0;
      r_test <= 1'b0;
    end else if (write) begin
      if (w_is_mv) begin
        r_mv[address[3:0]] <= writedata;
      end else if (w_is_mvp) begin
        r_mvp[address[3:0]] <= writedata;
      end else begin
        case (address)
          ADDR_LIGHT:          r_light[0] <= writedata;
          ADDR_LIGHT + 16'd1:  r_light[1] <= writedata;
          ADDR_LIGHT + 16'd2:  r_light[2] <= writedata;
          ADDR_FB:             r_fb       <= writedata[BASE_W-1:0];
          ADDR_VB:             r_vb       <= writedata[BASE_W-1:0];
          ADDR_TEST:           r_test     <= writedata[TEST_BIT];
          default:             ;
        endcase
      end
    end
  end

  // Completion wins over a start arriving in the same cycle: start is only honoured from IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_clr_done) r_done <= 1'b0;
          if (w_start_req) begin
            r_state <= BUSY;
            r_done  <= 1'b0;
            r_start <= 1'b1;
          end
        end
        BUSY: begin
          if (done_in) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_clr_done) begin
            r_done <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_mv) begin
      w_rdata = r_mv[address[3:0]];
    end else if (w_is_mvp) begin
      w_rdata = r_mvp[address[3:0]];
    end else begin
      case (address)
        ADDR_LIGHT:         w_rdata = r_light[0];
        ADDR_LIGHT + 16'd1: w_rdata = r_light[1];
        ADDR_LIGHT + 16'd2: w_rdata = r_light[2];
        ADDR_FB:            w_rdata = {{(DATA_W-BASE_W){1'b0}}, r_fb};
        ADDR_VB:            w_rdata = {{(DATA_W-BASE_W){1'b0}}, r_vb};
        ADDR_CTRL: begin
          w_rdata[STAT_BUSY_BIT] = w_busy;
          w_rdata[STAT_DONE_BIT] = r_done;
        end
        ADDR_TEST:          w_rdata[TEST_BIT] = r_test;
        default:            w_rdata = '0;
      endcase
    end
  end

  // Read data is captured from pre-edge state, so a same-cycle write to the same word reads old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (read) begin
      r_rdata <= w_rdata;
    end
  end

  assign readdata           = r_rdata;
  assign MV                 = r_mv;
  assign MVP                = r_mvp;
  assign lighting           = r_light;
  assign frame_buffer_base  = r_fb;
  assign vertex_buffer_base = r_vb;
  assign start_render       = r_start;
  assign test               = r_test;

endmodule

// File: tb/tb_config_reg.sv
// Directed bench for config_reg: read expectations are queued at issue and checked by a separate monitor.
module tb_config_reg;
  import rast_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [31:0] readdata;
  logic [31:0] mv       [16];
  logic [31:0] mvp      [16];
  logic [31:0] lighting [3];
  logic [25:0] fb_base;
  logic [25:0] vb_base;
  logic        start_render;
  logic        test;
  logic        done_in;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  config_reg dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .writedata          (writedata),
    .write              (write),
    .read               (read),
    .address            (address),
    .readdata           (readdata),
    .MV                 (mv),
    .MVP                (mvp),
    .lighting           (lighting),
    .frame_buffer_base  (fb_base),
    .vertex_buffer_base (vb_base),
    .start_render       (start_render),
    .test               (test),
    .done_in            (done_in)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    read = 1'b1; address = a;
    exp_q.push_back(e);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  // Monitor: a read accepted on an edge is compared on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_n && read) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL readdata: got 0x%08h with no expected value queued", readdata);
        end else begin
          chk("readdata", readdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; write = 1'b0; read = 1'b0; done_in = 1'b0;
    address = '0; writedata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_start", 32'(start_render), 32'h0);
    chk("rst_test", 32'(test), 32'h0);
    chk("rst_fb", 32'(fb_base), 32'h0);
    chk("rst_vb", 32'(vb_base), 32'h0);
    chk("rst_mv5", mv[5], 32'h0);
    chk("rst_light2", lighting[2], 32'h0);
    rd(ADDR_CTRL, 32'h0);

    // Matrix path
    for (int i = 0; i < 16; i++) wr(16'(16'h10 + i), 32'h0001_0000 * (i + 1));
    rd(16'h001F, 32'h0010_0000);
    for (int i = 0; i < 16; i += 5) chk("mvp_out", mvp[i], 32'h0001_0000 * (i + 1));
    for (int i = 0; i < 16; i += 5) chk("mv_unchanged", mv[i], 32'h0);
    rd(16'h0013, 32'h0004_0000);

    // Base truncation
    wr(ADDR_FB, 32'hFFFF_FFFF);
    chk("fb_trunc", 32'(fb_base), 32'h03FF_FFFF);
    rd(ADDR_FB, 32'h03FF_FFFF);
    wr(ADDR_VB, 32'hABCD_EF12);
    chk("vb_trunc", 32'(vb_base), 32'h03CD_EF12);
    rd(ADDR_VB, 32'h03CD_EF12);

    // Lighting and same-cycle write/read
    wr(16'h0020, 32'hA0A0_A0A0);
    wr(16'h0021, 32'h3F80_0000);
    wr(16'h0022, 32'h0000_0042);
    chk("light1", lighting[1], 32'h3F80_0000);
    rd(16'h0021, 32'h3F80_0000);
    write = 1'b1; read = 1'b1; address = 16'h0020; writedata = 32'h1111_1111;
    exp_q.push_back(32'hA0A0_A0A0);
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    chk("light0_new", lighting[0], 32'h1111_1111);
    rd(16'h0020, 32'h1111_1111);

    // Start handshake
    wr(ADDR_CTRL, 32'h1);
    chk("start_pulse", 32'(start_render), 32'h1);
    idle(1);
    chk("start_one_cycle", 32'(start_render), 32'h0);
    rd(ADDR_CTRL, 32'h1);
    wr(ADDR_CTRL, 32'h1);
    chk("start_while_busy", 32'(start_render), 32'h0);
    rd(ADDR_CTRL, 32'h1);
    pulse_done();
    rd(ADDR_CTRL, 32'h2);
    wr(ADDR_CTRL, 32'h1);
    chk("restart_pulse", 32'(start_render), 32'h1);
    rd(ADDR_CTRL, 32'h1);
    chk("restart_low", 32'(start_render), 32'h0);

    // Start and done_in together while busy
    write = 1'b1; address = ADDR_CTRL; writedata = 32'h1; done_in = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; done_in = 1'b0;
    chk("simul_no_pulse", 32'(start_render), 32'h0);
    rd(ADDR_CTRL, 32'h2);
    chk("simul_no_late_pulse", 32'(start_render), 32'h0);

    // Done clear, done_in while idle
    wr(ADDR_CTRL, 32'h2);
    rd(ADDR_CTRL, 32'h0);
    pulse_done();
    rd(ADDR_CTRL, 32'h0);

    // Unmapped and test register
    wr(16'h0100, 32'h0000_DEAD);
    chk("unmapped_mv0", mv[0], 32'h0);
    chk("unmapped_fb", 32'(fb_base), 32'h03FF_FFFF);
    chk("unmapped_test", 32'(test), 32'h0);
    rd(16'h0100, 32'h0);
    rd(16'h0027, 32'h0);
    wr(ADDR_TEST, 32'h1);
    chk("test_bit", 32'(test), 32'h1);
    rd(ADDR_TEST, 32'h1);

    // Reset mid-operation
    wr(ADDR_MV, 32'h1234_5678);
    chk("mv0_written", mv[0], 32'h1234_5678);
    wr(ADDR_CTRL, 32'h1);
    chk("pre_reset_pulse", 32'(start_render), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_start", 32'(start_render), 32'h0);
    chk("arst_mv0", mv[0], 32'h0);
    chk("arst_mvp15", mvp[15], 32'h0);
    chk("arst_fb", 32'(fb_base), 32'h0);
    chk("arst_test", 32'(test), 32'h0);
    chk("arst_readdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rd(ADDR_CTRL, 32'h0);
    rd(16'h001F, 32'h0);
    chk("post_reset_start", 32'(start_render), 32'h0);

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
